// File: rtl/media_escala_param.sv
// Block-average / decimating downscaler: ROM source image -> VGA frame RAM, factor 2^L per frame.
// Optional MEDIA_ARRED_EN: round half-up in averaging mode instead of truncating.
module media_escala_param #(
    parameter int LARGURA  = 160,
    parameter int ALTURA   = 120,
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 19,
    parameter int MAX_LOG2 = 2,
    parameter int ROM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        log2_fator,
    input  logic              modo,
    input  logic [PIX_W-1:0]  pixel_rom,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] addr_ram_vga,
    output logic [PIX_W-1:0]  pixel_saida,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);
    localparam int                ACC_W    = PIX_W + 2 * MAX_LOG2;
    localparam logic [1:0]        MAX_L    = 2'(MAX_LOG2);
    localparam logic [ROM_LAT-1:0] LOW_MASK = ROM_LAT'((1 << (ROM_LAT - 1)) - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          l_q, l_d;
    logic                m_q, m_d;
    logic [ADDR_W-1:0]   sx_q, sx_d, sy_q, sy_d, bx_q, bx_d, by_q, by_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ROM_LAT-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d, addr_ram_q, addr_ram_d;
    logic [PIX_W-1:0]    pixel_q, pixel_d;
    logic                wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;

    logic [1:0]          l_in;
    logic [ADDR_W-1:0]   nl_in, na_in, nl, na, f_m1;
    logic [2:0]          sh;
    logic [PIX_W-1:0]    avg;

    function automatic logic [ADDR_W-1:0] src_addr(input logic [ADDR_W-1:0] bxi,
                                                   input logic [ADDR_W-1:0] byi,
                                                   input logic [ADDR_W-1:0] sxi,
                                                   input logic [ADDR_W-1:0] syi,
                                                   input logic [1:0]        li);
        src_addr = ((byi << li) + syi) * ADDR_W'(LARGURA) + (bxi << li) + sxi;
    endfunction

    assign l_in  = (log2_fator > MAX_L) ? MAX_L : log2_fator;
    assign nl_in = ADDR_W'(LARGURA) >> l_in;
    assign na_in = ADDR_W'(ALTURA) >> l_in;
    assign nl    = ADDR_W'(LARGURA) >> l_q;
    assign na    = ADDR_W'(ALTURA) >> l_q;
    assign f_m1  = (ONE << l_q) - ONE;
    assign sh    = {l_q, 1'b0};

    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        m_d        = m_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        bx_d       = bx_q;
        by_d       = by_q;
        acc_d      = acc_q;
        rom_addr_d = rom_addr_q;
        addr_ram_d = addr_ram_q;
        pixel_d    = pixel_q;
        wr_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        vld_d      = (vld_q << 1) | ROM_LAT'(state_q == READ);

        if (vld_q[ROM_LAT-1])
            acc_d = m_q ? ACC_W'(pixel_rom) : acc_q + ACC_W'(pixel_rom);

        avg = PIX_W'(acc_d >> sh);
`ifdef MEDIA_ARRED_EN
        if (l_q != 2'd0)
            avg = PIX_W'((acc_d + (ACC_W'(1) << (sh - 3'd1))) >> sh);
`endif

        case (state_q)
            IDLE: begin
                // busy still high here means this is the done cycle: start is not accepted
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    l_d    = l_in;
                    m_d    = modo;
                    busy_d = 1'b1;
                    sx_d   = '0;
                    sy_d   = '0;
                    bx_d   = '0;
                    by_d   = '0;
                    if (nl_in == '0 || na_in == '0) done_d = 1'b1;
                    else                            state_d = READ;
                end
            end
            READ: begin
                if (m_q || (sx_q == f_m1 && sy_q == f_m1)) begin
                    sx_d    = '0;
                    sy_d    = '0;
                    state_d = DRAIN;
                end else if (sx_q == f_m1) begin
                    sx_d = '0;
                    sy_d = sy_q + ONE;
                end else begin
                    sx_d = sx_q + ONE;
                end
            end
            DRAIN: begin
                // only the sample being captured this cycle may still be in flight
                if ((vld_q & LOW_MASK) == '0) begin
                    state_d    = WRITE;
                    wr_en_d    = 1'b1;
                    addr_ram_d = by_q * nl + bx_q;
                    pixel_d    = m_q ? PIX_W'(acc_d) : avg;
                end
            end
            WRITE: begin
                acc_d = '0;
                if (bx_q == nl - ONE) begin
                    bx_d = '0;
                    if (by_q == na - ONE) begin
                        by_d    = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        by_d    = by_q + ONE;
                        state_d = READ;
                    end
                end else begin
                    bx_d    = bx_q + ONE;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == READ)
            rom_addr_d = src_addr(bx_d, by_d, sx_d, sy_d, l_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            l_q        <= '0;
            m_q        <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            acc_q      <= '0;
            vld_q      <= '0;
            rom_addr_q <= '0;
            addr_ram_q <= '0;
            pixel_q    <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            m_q        <= m_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            acc_q      <= acc_d;
            vld_q      <= vld_d;
            rom_addr_q <= rom_addr_d;
            addr_ram_q <= addr_ram_d;
            pixel_q    <= pixel_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign addr_ram_vga = addr_ram_q;
    assign pixel_saida  = pixel_q;
    assign wr_en        = wr_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_media_escala_param.sv
// Bench for media_escala_param: 8x4 source (pixel = address), two instances with ROM latency 1 and 3.
module tb_media_escala_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  log2_fator = 2'd0;
    logic        modo = 1'b0;
    logic [7:0]  pix_a, pix_b;
    logic [18:0] rom_a, rom_b, waddr_a, waddr_b;
    logic [7:0]  pout_a, pout_b;
    logic        wr_a, wr_b, busy_a, busy_b, done_a, done_b;

    logic [7:0]  pipe_a = 8'd0;
    logic [7:0]  pipe_b[3] = '{default: 8'd0};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int w_addr[2][64];
    int w_pix[2][64];
    int w_cyc[2][64];
    int nw[2];
    int nd[2];
    int done_cyc[2];
    logic [18:0] rom_seen_a[4];
    logic [18:0] rom_seen_b[4];
    logic busy_seen;

    typedef struct {
        int              id;
        logic [1:0]      l;
        logic            m;
        bit              mid;
        bit              ident;
        int              n;
        int              blk1;
        int              blk3;
        logic [7:0][7:0] pix;
    } vec_t;

    vec_t vecs[6];

    media_escala_param #(.LARGURA(8), .ALTURA(4), .PIX_W(8), .ADDR_W(19), .MAX_LOG2(2), .ROM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .log2_fator(log2_fator), .modo(modo),
        .pixel_rom(pix_a), .rom_addr(rom_a), .addr_ram_vga(waddr_a), .pixel_saida(pout_a),
        .wr_en(wr_a), .busy(busy_a), .done(done_a));

    media_escala_param #(.LARGURA(8), .ALTURA(4), .PIX_W(8), .ADDR_W(19), .MAX_LOG2(2), .ROM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .log2_fator(log2_fator), .modo(modo),
        .pixel_rom(pix_b), .rom_addr(rom_b), .addr_ram_vga(waddr_b), .pixel_saida(pout_b),
        .wr_en(wr_b), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        pipe_a    <= rom_a[7:0];
        pipe_b[0] <= rom_b[7:0];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign pix_a = pipe_a;
    assign pix_b = pipe_b[2];

    always @(negedge clk) begin
        if (wr_a) begin
            if (nw[0] < 64) begin
                w_addr[0][nw[0]] = int'(waddr_a);
                w_pix[0][nw[0]]  = int'(pout_a);
                w_cyc[0][nw[0]]  = cyc;
            end
            nw[0] = nw[0] + 1;
        end
        if (wr_b) begin
            if (nw[1] < 64) begin
                w_addr[1][nw[1]] = int'(waddr_b);
                w_pix[1][nw[1]]  = int'(pout_b);
                w_cyc[1][nw[1]]  = cyc;
            end
            nw[1] = nw[1] + 1;
        end
        if (done_a) begin
            done_cyc[0] = cyc;
            nd[0] = nd[0] + 1;
        end
        if (done_b) begin
            done_cyc[1] = cyc;
            nd[1] = nd[1] + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int id, input logic [1:0] l, input logic m, input bit mid,
                                input bit ident, input int n, input int b1, input int b3,
                                input logic [63:0] pix);
        vec_t v;
        v.id = id; v.l = l; v.m = m; v.mid = mid; v.ident = ident;
        v.n = n; v.blk1 = b1; v.blk3 = b3; v.pix = pix;
        return v;
    endfunction

    task automatic clear_log();
        nw[0] = 0; nw[1] = 0; nd[0] = 0; nd[1] = 0;
        done_cyc[0] = 0; done_cyc[1] = 0;
    endtask

    task automatic run_frame(input logic [1:0] l, input logic m, input bit mid, input bit dstart,
                             output int s_cyc);
        @(negedge clk); #2;
        clear_log();
        log2_fator = l;
        modo = m;
        start = 1'b1;
        s_cyc = cyc;
        busy_seen = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk); #2;
            start = ((mid && k == 7) || (dstart && done_a)) ? 1'b1 : 1'b0;
            log2_fator = ~l;
            modo = ~m;
            if (k == 0) busy_seen = busy_a & busy_b;
            if (k < 4) begin
                rom_seen_a[k] = rom_a;
                rom_seen_b[k] = rom_b;
            end
            if (nd[0] > 0 && nd[1] > 0) break;
        end
        @(negedge clk); #2;
        start = 1'b0;
        chk("frame_completes", int'(nd[0] > 0 && nd[1] > 0), 1);
    endtask

    task automatic verify(input vec_t v, input int s_cyc);
        for (int d = 0; d < 2; d++) begin
            int blk;
            blk = (d == 0) ? v.blk1 : v.blk3;
            chk($sformatf("v%0d_lat%0d_nwrites", v.id, d * 2 + 1), nw[d], v.n);
            for (int i = 0; i < v.n && i < nw[d]; i++) begin
                int ep;
                ep = v.ident ? i : int'(v.pix[i % 8]);
                chk($sformatf("v%0d_lat%0d_addr%0d", v.id, d * 2 + 1, i), w_addr[d][i], i);
                chk($sformatf("v%0d_lat%0d_pix%0d", v.id, d * 2 + 1, i), w_pix[d][i], ep);
                chk($sformatf("v%0d_lat%0d_gap%0d", v.id, d * 2 + 1, i),
                    w_cyc[d][i] - ((i == 0) ? s_cyc : w_cyc[d][i-1]), blk);
            end
            chk($sformatf("v%0d_lat%0d_ndone", v.id, d * 2 + 1), nd[d], 1);
            if (nw[d] > 0 && nw[d] <= 64)
                chk($sformatf("v%0d_lat%0d_done_after_last", v.id, d * 2 + 1),
                    done_cyc[d] - w_cyc[d][nw[d]-1], 1);
        end
        @(negedge clk); #2;
        chk($sformatf("v%0d_busy_low_after", v.id), int'(busy_a | busy_b), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int s;
`ifdef MEDIA_ARRED_EN
        vecs[0] = mk(0, 2'd1, 1'b0, 1'b0, 1'b0, 8, 6, 8, {8'd27, 8'd25, 8'd23, 8'd21, 8'd11, 8'd9, 8'd7, 8'd5});
        vecs[2] = mk(2, 2'd3, 1'b0, 1'b0, 1'b0, 2, 18, 20, {48'd0, 8'd18, 8'd14});
        vecs[5] = mk(5, 2'd1, 1'b0, 1'b1, 1'b0, 8, 6, 8, {8'd27, 8'd25, 8'd23, 8'd21, 8'd11, 8'd9, 8'd7, 8'd5});
`else
        vecs[0] = mk(0, 2'd1, 1'b0, 1'b0, 1'b0, 8, 6, 8, {8'd26, 8'd24, 8'd22, 8'd20, 8'd10, 8'd8, 8'd6, 8'd4});
        vecs[2] = mk(2, 2'd3, 1'b0, 1'b0, 1'b0, 2, 18, 20, {48'd0, 8'd17, 8'd13});
        vecs[5] = mk(5, 2'd1, 1'b0, 1'b1, 1'b0, 8, 6, 8, {8'd26, 8'd24, 8'd22, 8'd20, 8'd10, 8'd8, 8'd6, 8'd4});
`endif
        vecs[1] = mk(1, 2'd2, 1'b1, 1'b0, 1'b0, 2, 3, 5, {48'd0, 8'd4, 8'd0});
        vecs[3] = mk(3, 2'd1, 1'b1, 1'b0, 1'b0, 8, 3, 5, {8'd22, 8'd20, 8'd18, 8'd16, 8'd6, 8'd4, 8'd2, 8'd0});
        vecs[4] = mk(4, 2'd0, 1'b0, 1'b0, 1'b1, 32, 3, 5, 64'd0);
        clear_log();

        // reset state
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs_lat1", int'(|{rom_a, waddr_a, pout_a, wr_a, busy_a, done_a}), 0);
        chk("reset_outputs_lat3", int'(|{rom_b, waddr_b, pout_b, wr_b, busy_b, done_b}), 0);
        rst_n = 1'b1;

        // first frame: busy and ROM address order of the first block
        run_frame(2'd1, 1'b0, 1'b0, 1'b0, s);
        chk("busy_after_start", int'(busy_seen), 1);
        chk("rom_a_0", int'(rom_seen_a[0]), 0);
        chk("rom_a_1", int'(rom_seen_a[1]), 1);
        chk("rom_a_2", int'(rom_seen_a[2]), 8);
        chk("rom_a_3", int'(rom_seen_a[3]), 9);
        chk("rom_b_0", int'(rom_seen_b[0]), 0);
        chk("rom_b_3", int'(rom_seen_b[3]), 9);
        verify(vecs[0], s);

        // reset in the middle of a frame
        @(negedge clk); #2;
        log2_fator = 2'd1; modo = 1'b0; start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs_lat1", int'(|{rom_a, waddr_a, pout_a, wr_a, busy_a, done_a}), 0);
        chk("midreset_outputs_lat3", int'(|{rom_b, waddr_b, pout_b, wr_b, busy_b, done_b}), 0);
        clear_log();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #2;
        chk("midreset_no_writes", nw[0] + nw[1], 0);
        chk("midreset_no_done", nd[0] + nd[1], 0);

        // table: each vector is a full frame on both instances
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].l, vecs[i].m, vecs[i].mid, 1'b0, s);
            verify(vecs[i], s);
        end

        // start offered in the done cycle is ignored
        run_frame(2'd2, 1'b1, 1'b0, 1'b1, s);
        verify(vecs[1], s);
        repeat (10) @(negedge clk);
        #2;
        chk("done_cycle_start_no_writes_lat1", nw[0], 2);
        chk("done_cycle_start_no_writes_lat3", nw[1], 2);
        chk("done_cycle_start_idle", int'(busy_a | busy_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/media_escala_param.md
Name: media_escala_param

Overview:
- Parametrised block-average downscaler. Reads a LARGURA x ALTURA source image from a synchronous ROM with configurable read latency. Writes a downscaled image to the VGA frame RAM.
- Scale factor is 2^log2_fator, selected per frame: 1, 2, 4 … 2^MAX_LOG2.
- Two modes: block average, or decimation (top-left sample of each block).
- A start/busy/done handshake lets the top-level FSM retrigger frames without a reset.

Parameters:
- LARGURA, 160, source width in pixels.
- ALTURA, 120, source height in pixels.
- PIX_W, 8, pixel width in bits.
- ADDR_W, 19, ROM and RAM address width.
- MAX_LOG2, 2, largest supported log2 of the factor.
- ROM_LAT, 1, ROM read latency in cycles (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- log2_fator  in  2  factor exponent; values above MAX_LOG2 are clamped to MAX_LOG2.
- modo  in  1  0 = block average, 1 = decimation.
- pixel_rom  in  PIX_W  ROM data, valid ROM_LAT cycles after rom_addr.
- rom_addr  out  ADDR_W  ROM read address.
- addr_ram_vga  out  ADDR_W  RAM write address.
- pixel_saida  out  PIX_W  RAM write data.
- wr_en  out  1  RAM write strobe, one cycle per output pixel.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last wr_en of a frame.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; all counters and the accumulator 0.
- IDLE:
  - start=1 latches log2_fator (clamped) and modo as L and M. Every later change of these inputs is ignored until the next frame.
  - F = 1<<L; NL = LARGURA>>L; NA = ALTURA>>L (floor).
  - Source rows and columns beyond NA*F / NL*F are never read.
  - Sets busy=1 and goes to READ.
- start while busy is ignored, with no effect on the frame in progress.
- READ:
  - One ROM address per cycle: rom_addr = (by*F+sy)*LARGURA + bx*F + sx.
  - sx is inner, sy outer, each running 0..F-1. M=1 issues only the (0,0) sample.
  - After the last address, goes to DRAIN.
- Return path: data is captured exactly ROM_LAT cycles after each issued address, tracked by a ROM_LAT-deep valid shift register.
  - M=0: acc accumulates every captured sample.
  - M=1: acc is loaded with the single captured sample.
  - acc width is PIX_W+2*MAX_LOG2 and never overflows.
- DRAIN: waits until all outstanding samples are captured, then goes to WRITE.
- WRITE (one cycle):
  - pixel_saida = acc >> (2L) when M=0, acc when M=1.
  - addr_ram_vga = by*NL + bx.
  - wr_en=1; acc is cleared.
  - Advances bx, wrapping at NL-1 to 0 and incrementing by.
  - After block (NL-1, NA-1): done=1 for one cycle, busy=0, bx=by=0, go to IDLE. Otherwise return to READ.
- addr_ram_vga and pixel_saida hold their values between strobes. wr_en is never high in any state other than WRITE.
- Timing:
  - Cycles per block: F² (M=0) or 1 (M=1), plus ROM_LAT, plus 1.
  - First rom_addr appears the cycle after start is accepted.
- F=1 (L=0): passthrough copy; NL=LARGURA, NA=ALTURA.
- Degenerate size: if NL=0 or NA=0, the frame produces no writes. done pulses the cycle after start, and busy is asserted for that one cycle.
- Reset mid-frame: immediate abort to IDLE. No partial done; no further wr_en.
- Start in the same cycle as done: ignored, because the block is still busy in that cycle.

Optional Feature:
- Macro: MEDIA_ARRED_EN.
- Defined: in M=0 with L>0, pixel_saida = (acc + (1<<(2L-1))) >> (2L), i.e. round half-up. The result cannot exceed 2^PIX_W-1.
- Undefined: truncating shift as above.
- Decimation and F=1 are unaffected either way.

Test Plan:
- Bench setup: LARGURA=8, ALTURA=4, ROM_LAT=1, ROM content = address (low 8 bits).
- L=1, M=0, start:
  - First write: addr_ram_vga=0, pixel_saida=4 (sum of 0,1,8,9 is 18; 18>>2=4); 5 when MEDIA_ARRED_EN is defined.
  - 8 wr_en pulses in total; last write at addr 7 with pixel 26; done one cycle after it.
- L=2, M=1, source 8x4:
  - Writes addr0=0 and addr1=4.
  - done after 2 writes; each block takes 3 cycles.
- L=3 with MAX_LOG2=2:
  - Clamped to F=4; average of the 4x4 block at origin = 216/16 = 13.
  - 2 writes.
- ROM_LAT=3, L=1, M=0: identical write values and addresses to the L=1 case; 4+3+1 cycles per block.
- Control corners:
  - start pulsed mid-frame: ignored, with identical output sequence.
  - rst_n low mid-frame: outputs 0 immediately, no done.
  - A new start afterwards completes a full frame.
